fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- IF-stage producer for the IF/ID pipeline register: owns the PC, issues instruction-memory requests, and drives PC/jalPC/jrPC/OpCode toward IF/ID.
- Generates the IF/ID hold (Nop) and flush (IF_Flush) controls.
- Applies ID-resolved redirects (branch, j/jal, jr), tolerates multi-cycle instruction memory, and discards wrong-path responses.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- Clk  in  1  clock; all state updates on posedge.
- PcReSet_n  in  1  reset; asynchronous, active-low.
- Stall  in  1  hazard unit: ID cannot accept a new instruction.
- Branch  in  1  taken conditional branch resolved in ID.
- BrOffset  in  32  sign-extended branch immediate (word offset).
- jump  in  1  j/jal in ID.
- jumpstr  in  26  jump index field from ID.
- jr  in  1  jr in ID.
- JrAddr  in  32  rs register value for jr.
- BrPC  in  32  PC of the instruction currently in ID.
- im_req  out  1  instruction-memory request, level.
- im_addr  out  32  request address, word aligned.
- im_ack  in  1  response valid; may assert in the same cycle as im_req.
- im_rdata  in  32  instruction word, valid with im_ack.
- PC  out  32  address of the instruction presented on OpCode.
- jalPC  out  32  link address, PC+4.
- jrPC  out  32  next sequential fetch address.
- OpCode  out  32  instruction word to IF/ID.
- Nop  out  1  IF/ID hold, equal to Stall.
- IF_Flush  out  1  IF/ID bubble insert.

Behaviour:
- Reset values (async, PcReSet_n=0):
  - pc_q=RESET_PC, state=REQ, buffer=0, OpCode=0, IF_Flush=1, im_req=0.
  - im_req rises on the first Clk edge after reset release.
- Target computation (combinational, 32-bit, wrap modulo 2^32):
  - branch: BrPC+4+(BrOffset<<2)
  - jump: {BrPC+4[31:28], jumpstr, 2'b00}
  - jr: {JrAddr[31:2], 2'b00}
- Redirect priority: jr > jump > Branch. Any redirect overrides Stall.
- Redirect effects: pc_q<=target; IF_Flush=1 in the redirect cycle (clears the wrong-path instruction entering IF/ID); Nop forced 0.
- States:
  - REQ: im_req=1, im_addr=pc_q.
    - ack & !Stall & !redirect: OpCode=im_rdata, PC=pc_q; pc_q<=pc_q+4; stay REQ. Throughput is 1 instr/cycle with a zero-wait memory.
    - ack & Stall: capture im_rdata into buffer; go HOLD.
    - !ack: OpCode=0, IF_Flush=1 (bubble); stay REQ.
    - redirect & !ack: go DROP; the outstanding address is latched.
    - redirect & ack: discard response; stay REQ at target.
  - HOLD: im_req=0; OpCode=buffer.
    - Stall: stay HOLD.
    - !Stall: pc_q<=pc_q+4; go REQ.
    - redirect: discard buffer; go REQ.
  - DROP: im_req=1 with the latched old address held stable until ack; OpCode=0, IF_Flush=1.
    - ack: discard response; go REQ at pc_q.
    - A further redirect in DROP only updates pc_q.
- Handshake rule: once asserted, im_req and im_addr stay constant until the cycle of im_ack.
- Output rules:
  - jalPC=PC+4.
  - jrPC is the registered next fetch address: pc_q after the update, or the target on redirect.
  - PC increment wraps 32'hFFFF_FFFC to 0.
- Reset mid-transaction: abandons any outstanding request. The memory must tolerate request withdrawal.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - Adds outputs FetchCnt, BubbleCnt, RedirCnt (CNT_W each, reset 0, saturating at all-ones).
  - Increments: FetchCnt on instructions delivered; BubbleCnt on cycles with IF_Flush=1 not caused by redirect; RedirCnt on redirects.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg:
  - state enum FS_REQ/FS_HOLD/FS_DROP
  - RESET_PC default
  - function jump_target(pc4, idx)
- Sub-module fetch_target_mux (combinational priority redirect and target selection). Everything else stays in the top module.

Test Plan:
- Reset, zero-wait memory (ack same cycle), Stall=0 -> PC sequence 3000,3004,3008; OpCode matches memory; IF_Flush=0 from the second cycle.
- Stall=1 for 3 cycles mid-stream -> Nop=1 for those cycles; im_req=0 in HOLD; buffered OpCode stable; resumes at next PC+4 with no loss or duplication.
- Branch=1, BrPC=3008, BrOffset=-2 -> IF_Flush=1 for one cycle; next fetch address 3004.
- 3-cycle memory latency, jump with jumpstr=0x0000C10 during the wait -> DROP; im_addr held at the old address until ack; response discarded; next request to 00003040.
- jr and Branch asserted in the same cycle, JrAddr=0x0000_3101 -> jr wins; fetch 00003100; Stall asserted simultaneously is ignored.
- PcReSet_n pulsed low mid-wait -> im_req drops asynchronously; restart at 3000; counters (if FETCH_PERF_CNT_EN) are zero.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the IF-stage fetch unit.
// State encoding, reset PC default and the j/jal target function.
package fetch_pkg;

    typedef enum logic [1:0] {
        FS_REQ,
        FS_HOLD,
        FS_DROP
    } fstate_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    function automatic logic [31:0] jump_target(
        input logic [31:0] pc4,
        input logic [25:0] idx
    );
        return {pc4[31:28], idx, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/response bundle.
// Request is a level held stable until the cycle of im_ack.
interface fetch_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;

    modport master (
        output im_req,
        output im_addr,
        input  im_ack,
        input  im_rdata
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_ack,
        output im_rdata
    );
endinterface

// File: rtl/fetch_target_mux.sv
// fetch_target_mux: ID-resolved redirect detect and target select.
// Priority is jr over jump over taken branch.
module fetch_target_mux
    import fetch_pkg::*;
(
    input  logic        Branch,
    input  logic [31:0] BrOffset,
    input  logic        jump,
    input  logic [25:0] jumpstr,
    input  logic        jr,
    input  logic [31:0] JrAddr,
    input  logic [31:0] BrPC,
    output logic        redirect,
    output logic [31:0] target
);

    logic [31:0] pc4;

    assign pc4 = BrPC + 32'd4;

    always_comb begin
        redirect = jr | jump | Branch;
        target   = pc4 + (BrOffset << 2);
        priority case (1'b1)
            jr:      target = {JrAddr[31:2], 2'b00};
            jump:    target = jump_target(pc4, jumpstr);
            default: target = pc4 + (BrOffset << 2);
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage - PC, imem requests, IF/ID hold/flush, redirects.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/bubble/redirect counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
`ifdef FETCH_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic        Clk,
    input  logic        PcReSet_n,
    input  logic        Stall,
    input  logic        Branch,
    input  logic [31:0] BrOffset,
    input  logic        jump,
    input  logic [25:0] jumpstr,
    input  logic        jr,
    input  logic [31:0] JrAddr,
    input  logic [31:0] BrPC,
    fetch_if.master     imem,
    output logic [31:0] PC,
    output logic [31:0] jalPC,
    output logic [31:0] jrPC,
    output logic [31:0] OpCode,
    output logic        Nop,
    output logic        IF_Flush
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] FetchCnt,
    output logic [CNT_W-1:0] BubbleCnt,
    output logic [CNT_W-1:0] RedirCnt
`endif
);

    fstate_e     state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] drop_q, drop_d;
    logic        req_en_q, req_en_d;
    logic [31:0] pc_inc, target;
    logic        req, ack, redirect;

    fetch_target_mux u_mux (
        .Branch   (Branch),
        .BrOffset (BrOffset),
        .jump     (jump),
        .jumpstr  (jumpstr),
        .jr       (jr),
        .JrAddr   (JrAddr),
        .BrPC     (BrPC),
        .redirect (redirect),
        .target   (target)
    );

    // req_en_q keeps im_req low until the first edge after reset release
    assign req_en_d     = 1'b1;
    assign pc_inc       = pc_q + 32'd4;
    assign req          = (state_q == FS_DROP) |
                          ((state_q == FS_REQ) & req_en_q);
    assign ack          = req & imem.im_ack;
    assign imem.im_req  = req;
    assign imem.im_addr = (state_q == FS_DROP) ? drop_q : pc_q;
    assign Nop          = Stall & ~redirect;
    assign jalPC        = PC + 32'd4;
    assign jrPC         = pc_d;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        buf_d    = buf_q;
        drop_d   = drop_q;
        OpCode   = '0;
        PC       = pc_q;
        IF_Flush = 1'b1;
        unique case (state_q)
            FS_REQ: begin
                if (ack) begin
                    OpCode   = imem.im_rdata;
                    IF_Flush = 1'b0;
                    if (Stall) begin
                        buf_d   = imem.im_rdata;
                        state_d = FS_HOLD;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            FS_HOLD: begin
                OpCode   = buf_q;
                IF_Flush = 1'b0;
                if (!Stall) begin
                    pc_d    = pc_inc;
                    state_d = FS_REQ;
                end
            end
            FS_DROP: begin
                if (ack) state_d = FS_REQ;
            end
            default: state_d = FS_REQ;
        endcase
        // an unanswered request must drain at its old address
        if (redirect) begin
            OpCode   = '0;
            IF_Flush = 1'b1;
            pc_d     = target;
            state_d  = (req & ~ack) ? FS_DROP : FS_REQ;
            if (state_q != FS_DROP) drop_d = pc_q;
        end
    end

    always_ff @(posedge Clk or negedge PcReSet_n) begin
        if (!PcReSet_n) begin
            state_q  <= FS_REQ;
            pc_q     <= RESET_PC;
            buf_q    <= '0;
            drop_q   <= '0;
            req_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            buf_q    <= buf_d;
            drop_q   <= drop_d;
            req_en_q <= req_en_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic             deliver, bubble;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic             en
    );
        return (en && !(&v)) ? v + CNT_ONE : v;
    endfunction

    assign deliver = ~redirect & ~Stall &
                     (((state_q == FS_REQ) & ack) | (state_q == FS_HOLD));
    assign bubble  = IF_Flush & ~redirect;

    always_comb begin
        fetch_cnt_d  = sat_inc(fetch_cnt_q, deliver);
        bubble_cnt_d = sat_inc(bubble_cnt_q, bubble);
        redir_cnt_d  = sat_inc(redir_cnt_q, redirect);
    end

    always_ff @(posedge Clk or negedge PcReSet_n) begin
        if (!PcReSet_n) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            redir_cnt_q  <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            redir_cnt_q  <= redir_cnt_d;
        end
    end

    assign FetchCnt  = fetch_cnt_q;
    assign BubbleCnt = bubble_cnt_q;
    assign RedirCnt  = redir_cnt_q;
`endif

endmodule
